// File: rtl/keyboard.sv
// PS/2 key-event decoder producing a held ASCII / Famicom button code.
// Drives 0xFF while no mapped key is held.
module keyboard (
    input  logic        pulse,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [2:0]  kb_lang,
    output logic [7:0]  ascii_code,
    output logic        caps_lock
);

    localparam int unsigned CODE_W = 8;
    localparam logic [CODE_W-1:0] IDLE_CODE = 8'hFF;

    logic              prev_tog;
    logic              lshift;
    logic              rshift;
    logic              ctrl;
    logic              cur_ext;
    logic [CODE_W-1:0] cur_code;

    logic              evt;
    logic              is_make;
    logic              is_ext;
    logic [CODE_W-1:0] code;
    logic              shift;

    assign evt     = ps2_key[10] != prev_tog;
    assign is_make = ps2_key[9];
    assign is_ext  = ps2_key[8];
    assign code    = ps2_key[7:0];
    assign shift   = lshift | rshift;

    logic [CODE_W-1:0] sc;
    logic              is_letter;
    logic [CODE_W-1:0] letter;
    logic              is_sym;
    logic [CODE_W-1:0] sym_lo;
    logic [CODE_W-1:0] sym_hi;
    logic              map_valid;
    logic [CODE_W-1:0] map_val;

    // Scancode-to-code lookup using the current modifier state.
    always_comb begin
        sc        = code;
        is_letter = 1'b1;
        letter    = '0;
        is_sym    = 1'b1;
        sym_lo    = '0;
        sym_hi    = '0;
        map_valid = 1'b0;
        map_val   = IDLE_CODE;

        if (kb_lang == 3'd1 && code == 8'h35) sc = 8'h1A;
        else if (kb_lang == 3'd1 && code == 8'h1A) sc = 8'h35;

        case (sc)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            default: is_letter = 1'b0;
        endcase

        case (code)
            8'h16: begin sym_lo = 8'h31; sym_hi = 8'h21; end
            8'h1E: begin sym_lo = 8'h32; sym_hi = 8'h40; end
            8'h26: begin sym_lo = 8'h33; sym_hi = 8'h23; end
            8'h25: begin sym_lo = 8'h34; sym_hi = 8'h24; end
            8'h2E: begin sym_lo = 8'h35; sym_hi = 8'h25; end
            8'h36: begin sym_lo = 8'h36; sym_hi = 8'h5E; end
            8'h3D: begin sym_lo = 8'h37; sym_hi = 8'h26; end
            8'h3E: begin sym_lo = 8'h38; sym_hi = 8'h2A; end
            8'h46: begin sym_lo = 8'h39; sym_hi = 8'h28; end
            8'h45: begin sym_lo = 8'h30; sym_hi = 8'h29; end
            8'h4E: begin sym_lo = 8'h2D; sym_hi = 8'h5F; end
            8'h55: begin sym_lo = 8'h3D; sym_hi = 8'h2B; end
            8'h54: begin sym_lo = 8'h5B; sym_hi = 8'h7B; end
            8'h5B: begin sym_lo = 8'h5D; sym_hi = 8'h7D; end
            8'h5D: begin sym_lo = 8'h5C; sym_hi = 8'h7C; end
            8'h4C: begin sym_lo = 8'h3B; sym_hi = 8'h3A; end
            8'h52: begin sym_lo = 8'h27; sym_hi = 8'h22; end
            8'h41: begin sym_lo = 8'h2C; sym_hi = 8'h3C; end
            8'h49: begin sym_lo = 8'h2E; sym_hi = 8'h3E; end
            8'h4A: begin sym_lo = 8'h2F; sym_hi = 8'h3F; end
            8'h0E: begin sym_lo = 8'h60; sym_hi = 8'h7E; end
            8'h29: begin sym_lo = 8'h20; sym_hi = 8'h20; end
            8'h5A: begin sym_lo = 8'h0A; sym_hi = 8'h0A; end
            8'h66: begin sym_lo = 8'h7F; sym_hi = 8'h7F; end
            8'h0D: begin sym_lo = 8'h09; sym_hi = 8'h09; end
            8'h76: begin sym_lo = 8'h1B; sym_hi = 8'h1B; end
            default: is_sym = 1'b0;
        endcase

        if (is_ext) begin
            map_valid = 1'b1;
            case (code)
                8'h75:   map_val = 8'hF7;
                8'h72:   map_val = 8'hFB;
                8'h6B:   map_val = 8'hFD;
                8'h74:   map_val = 8'hFE;
                8'h5A:   map_val = 8'h0A;
                default: map_valid = 1'b0;
            endcase
        end else if (is_letter) begin
            map_valid = 1'b1;
            // Lowercase & 0x1F equals uppercase & 0x1F, so ctrl needs no case fold.
            if (ctrl)                   map_val = letter & 8'h1F;
            else if (shift ^ caps_lock) map_val = letter - 8'h20;
            else                        map_val = letter;
        end else if (is_sym) begin
            map_valid = 1'b1;
            map_val   = shift ? sym_hi : sym_lo;
        end
    end

    // Event processing: modifiers, held-key capture and release.
    always_ff @(posedge pulse or negedge reset) begin
        if (!reset) begin
            prev_tog   <= 1'b0;
            lshift     <= 1'b0;
            rshift     <= 1'b0;
            ctrl       <= 1'b0;
            caps_lock  <= 1'b0;
            cur_ext    <= 1'b0;
            cur_code   <= '0;
            ascii_code <= IDLE_CODE;
        end else begin
            prev_tog <= ps2_key[10];
            if (evt) begin
                if (!is_ext && code == 8'h12) begin
                    lshift <= is_make;
                end else if (!is_ext && code == 8'h59) begin
                    rshift <= is_make;
                end else if (code == 8'h14) begin
                    ctrl <= is_make;
                end else if (!is_ext && code == 8'h58) begin
                    if (is_make) caps_lock <= ~caps_lock;
                end else if (is_make) begin
                    if (map_valid) begin
                        ascii_code <= map_val;
                        cur_ext    <= is_ext;
                        cur_code   <= code;
                    end
                end else if (is_ext == cur_ext && code == cur_code) begin
                    ascii_code <= IDLE_CODE;
                    cur_ext    <= 1'b0;
                    cur_code   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keyboard.sv
// Directed self-checking bench for the PS/2 keyboard decoder.
module tb_keyboard;

    logic        pulse;
    logic        reset;
    logic [10:0] ps2_key;
    logic [2:0]  kb_lang;
    logic [7:0]  ascii_code;
    logic        caps_lock;

    logic        tog;
    int          n_pass;
    int          n_total;

    keyboard dut (
        .pulse      (pulse),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .kb_lang    (kb_lang),
        .ascii_code (ascii_code),
        .caps_lock  (caps_lock)
    );

    initial pulse = 1'b0;
    always #5 pulse = ~pulse;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    // One PS/2 event, then sample just after the edge that consumes it.
    task automatic send(input logic mk, input logic ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, mk, ext, code};
        @(posedge pulse);
        #1;
    endtask

    task automatic idle_edge();
        @(posedge pulse);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        tog     = 1'b0;
        ps2_key = '0;
        kb_lang = 3'd0;
        reset   = 1'b0;
        repeat (3) @(posedge pulse);
        #1;
        check("reset_ascii", ascii_code, 8'hFF);
        check("reset_caps", {7'b0, caps_lock}, 8'h00);
        @(negedge pulse);
        reset = 1'b1;
        repeat (2) idle_edge();
        check("idle_after_reset", ascii_code, 8'hFF);

        send(1'b1, 1'b0, 8'h1C); check("make_a", ascii_code, 8'h61);
        send(1'b0, 1'b0, 8'h1C); check("break_a", ascii_code, 8'hFF);

        send(1'b1, 1'b0, 8'h12); check("shift_no_change", ascii_code, 8'hFF);
        send(1'b1, 1'b0, 8'h1C); check("shift_A", ascii_code, 8'h41);
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h12);

        send(1'b1, 1'b0, 8'h58); check("caps_on", {7'b0, caps_lock}, 8'h01);
        check("caps_no_ascii", ascii_code, 8'hFF);
        send(1'b1, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h1C); check("caps_shift_a", ascii_code, 8'h61);
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h16); check("caps_digit", ascii_code, 8'h31);
        send(1'b0, 1'b0, 8'h16);
        send(1'b0, 1'b0, 8'h58); check("caps_break_ignored", {7'b0, caps_lock}, 8'h01);
        send(1'b1, 1'b0, 8'h58); check("caps_off", {7'b0, caps_lock}, 8'h00);
        send(1'b0, 1'b0, 8'h58);

        send(1'b1, 1'b0, 8'h14);
        send(1'b1, 1'b0, 8'h21); check("ctrl_c", ascii_code, 8'h03);
        send(1'b0, 1'b0, 8'h21); check("ctrl_c_break", ascii_code, 8'hFF);
        send(1'b0, 1'b0, 8'h14);
        send(1'b1, 1'b1, 8'h14);
        send(1'b1, 1'b0, 8'h1C); check("e0_ctrl_a", ascii_code, 8'h01);
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b1, 8'h14);

        send(1'b1, 1'b0, 8'h1C); check("roll_a", ascii_code, 8'h61);
        send(1'b1, 1'b0, 8'h32); check("roll_b", ascii_code, 8'h62);
        send(1'b0, 1'b0, 8'h1C); check("roll_break_old", ascii_code, 8'h62);
        send(1'b0, 1'b0, 8'h32); check("roll_break_new", ascii_code, 8'hFF);

        send(1'b1, 1'b1, 8'h75); check("ext_up", ascii_code, 8'hF7);
        send(1'b0, 1'b0, 8'h75); check("break_ext_mismatch", ascii_code, 8'hF7);
        send(1'b1, 1'b0, 8'h75); check("unmapped_75", ascii_code, 8'hF7);
        send(1'b0, 1'b1, 8'h75); check("ext_up_break", ascii_code, 8'hFF);
        send(1'b1, 1'b1, 8'h6B); check("ext_left", ascii_code, 8'hFD);
        send(1'b1, 1'b1, 8'h5A); check("kp_enter", ascii_code, 8'h0A);
        send(1'b0, 1'b1, 8'h5A); check("kp_enter_break", ascii_code, 8'hFF);

        kb_lang = 3'd1;
        send(1'b1, 1'b0, 8'h35); check("de_35_z", ascii_code, 8'h7A);
        send(1'b1, 1'b0, 8'h1A); check("de_1a_y", ascii_code, 8'h79);
        send(1'b0, 1'b0, 8'h1A); check("de_break", ascii_code, 8'hFF);
        kb_lang = 3'd5;
        send(1'b1, 1'b0, 8'h35); check("lang5_35_y", ascii_code, 8'h79);
        send(1'b0, 1'b0, 8'h35);
        kb_lang = 3'd0;

        ps2_key = {tog, 1'b1, 1'b0, 8'h1C};
        idle_edge(); check("no_toggle", ascii_code, 8'hFF);
        send(1'b1, 1'b0, 8'h16); check("digit_1", ascii_code, 8'h31);
        send(1'b1, 1'b0, 8'h12); check("latched_shift", ascii_code, 8'h31);
        send(1'b1, 1'b0, 8'h1E); check("shift_2_at", ascii_code, 8'h40);
        send(1'b1, 1'b0, 8'h4A); check("shift_slash_q", ascii_code, 8'h3F);
        send(1'b0, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h4A); check("slash", ascii_code, 8'h2F);
        send(1'b1, 1'b0, 8'h29); check("space", ascii_code, 8'h20);
        send(1'b1, 1'b0, 8'h76); check("esc", ascii_code, 8'h1B);
        send(1'b0, 1'b0, 8'h76); check("esc_break", ascii_code, 8'hFF);

        send(1'b1, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h1C); check("pre_reset_A", ascii_code, 8'h41);
        @(negedge pulse);
        reset   = 1'b0;
        #1;
        check("async_reset", ascii_code, 8'hFF);
        tog     = 1'b0;
        ps2_key = '0;
        @(negedge pulse);
        reset   = 1'b1;
        send(1'b0, 1'b0, 8'h1C); check("break_after_reset", ascii_code, 8'hFF);
        send(1'b1, 1'b0, 8'h1C); check("shift_cleared", ascii_code, 8'h61);

        @(negedge pulse);
        reset   = 1'b0;
        tog     = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h32};
        @(negedge pulse);
        reset   = 1'b1;
        idle_edge(); check("first_edge_event", ascii_code, 8'h62);
        idle_edge(); check("held_toggle", ascii_code, 8'h62);
        send(1'b0, 1'b0, 8'h32); check("first_edge_break", ascii_code, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
